// File: rtl/spike_window_counter.sv
// Windowed spike counter: population and watch-neuron spike counts over 2^WIN_LOG2 frames.
// Optional win_seq output when SPIKE_WINDOW_COUNTER_SEQ_EN is defined.
module spike_window_counter #(
  parameter int NN       = 8,
  parameter int WIN_LOG2 = 4,
  parameter int CW       = 24,
  parameter int SUBPH    = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [NN+2:0] slot_cnt,
  input  logic          spike_in,
  input  logic [NN:0]   watch_idx,
  output logic [CW-1:0] pop_cnt,
  output logic [CW-1:0] watch_cnt,
  output logic          cnt_valid,
  input  logic          cnt_ready,
  output logic          ovf_sticky,
  output logic          drop_sticky
`ifdef SPIKE_WINDOW_COUNTER_SEQ_EN
  ,
  output logic [15:0]   win_seq
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int            FW         = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'((1 << WIN_LOG2) - 1);
  localparam logic [1:0]    SUBPH_L    = 2'(SUBPH);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] a, input logic inc);
    if (inc && !(&a))
      return a + CW'(1);
    return a;
  endfunction

  logic [1:0]    state_p0;
  logic [CW-1:0] pop_acc_p0;
  logic [CW-1:0] watch_acc_p0;
  logic [FW-1:0] frame_cnt_p0;
  logic [NN:0]   watch_q_p0;

  logic          sync_hit;
  logic          counting;
  logic          sample;
  logic [NN:0]   watch_eff;
  logic [CW-1:0] pop_base;
  logic [CW-1:0] watch_base;
  logic          pop_inc;
  logic          watch_inc;
  logic [CW-1:0] pop_sum;
  logic [CW-1:0] watch_sum;
  logic          ovf_hit;
  logic          frame_end;
  logic          win_close;
  logic          load;

  // The SYNC cycle at slot 0 starts a window, so it counts from a zero base
  // against the freshly presented watch index.
  always_comb begin
    sync_hit   = enable && (state_p0 == ST_SYNC) && (slot_cnt == '0);
    counting   = enable && ((state_p0 == ST_RUN) || sync_hit);
    sample     = counting && (slot_cnt[1:0] == SUBPH_L);
    watch_eff  = sync_hit ? watch_idx : watch_q_p0;
    pop_base   = sync_hit ? '0 : pop_acc_p0;
    watch_base = sync_hit ? '0 : watch_acc_p0;
    pop_inc    = sample && spike_in;
    watch_inc  = pop_inc && (slot_cnt[NN+2:2] == watch_eff);
    pop_sum    = sat_inc(pop_base, pop_inc);
    watch_sum  = sat_inc(watch_base, watch_inc);
    ovf_hit    = (pop_inc && (&pop_base)) || (watch_inc && (&watch_base));
    frame_end  = enable && (state_p0 == ST_RUN) && (&slot_cnt);
    win_close  = frame_end && (frame_cnt_p0 == FRAME_LAST);
    load       = win_close && (!cnt_valid || cnt_ready);
  end

  // Stage p0: control state, accumulators and frame counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_p0     <= ST_IDLE;
      pop_acc_p0   <= '0;
      watch_acc_p0 <= '0;
      frame_cnt_p0 <= '0;
      watch_q_p0   <= '0;
      ovf_sticky   <= 1'b0;
    end else begin
      if (!enable)
        state_p0 <= ST_IDLE;
      else begin
        case (state_p0)
          ST_IDLE: state_p0 <= ST_SYNC;
          ST_SYNC: if (slot_cnt == '0) state_p0 <= ST_RUN;
          ST_RUN:  state_p0 <= ST_RUN;
          default: state_p0 <= ST_IDLE;
        endcase
      end

      if (counting) begin
        if (win_close) begin
          pop_acc_p0   <= '0;
          watch_acc_p0 <= '0;
          frame_cnt_p0 <= '0;
          watch_q_p0   <= watch_idx;
        end else begin
          pop_acc_p0   <= pop_sum;
          watch_acc_p0 <= watch_sum;
          if (sync_hit) begin
            frame_cnt_p0 <= '0;
            watch_q_p0   <= watch_idx;
          end else if (frame_end)
            frame_cnt_p0 <= frame_cnt_p0 + FW'(1);
        end
      end

      if (ovf_hit)
        ovf_sticky <= 1'b1;
    end
  end

  // Stage p1: valid/ready output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pop_cnt     <= '0;
      watch_cnt   <= '0;
      cnt_valid   <= 1'b0;
      drop_sticky <= 1'b0;
    end else begin
      if (load) begin
        pop_cnt   <= pop_sum;
        watch_cnt <= watch_sum;
        cnt_valid <= 1'b1;
      end else if (cnt_valid && cnt_ready)
        cnt_valid <= 1'b0;

      if (win_close && !load)
        drop_sticky <= 1'b1;
    end
  end

`ifdef SPIKE_WINDOW_COUNTER_SEQ_EN
  logic [15:0] seq_next_p0;

  // Dropped windows still advance the sequence so the host sees the gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_next_p0 <= '0;
      win_seq     <= '0;
    end else begin
      if (enable && (state_p0 == ST_IDLE))
        seq_next_p0 <= '0;
      else if (win_close)
        seq_next_p0 <= seq_next_p0 + 16'd1;
      if (load)
        win_seq <= seq_next_p0;
    end
  end
`endif

endmodule
